// File: rtl/voice_mixer_pkg.sv
// Shared types and width helpers for the voice mixer.
// Holds the FSM state encoding, the unity-gain constant for a Q1.(GAIN_W-1)
// gain, and the accumulator and address width functions.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Unity gain in Q1.(gain_w-1) is a single one in the top bit.
    function automatic logic [31:0] unity_gain(input int gain_w);
        return 32'(1) << (gain_w - 1);
    endfunction

    // One guard bit for the >1.0 gain range plus log2 of the voice count,
    // so a sum of worst-case products can never wrap.
    function automatic int acc_width(input int sample_w, input int num_voices);
        return sample_w + 1 + $clog2(num_voices);
    endfunction

    // Voice index width, never narrower than one bit.
    function automatic int addr_width(input int num_voices);
        return (num_voices > 1) ? $clog2(num_voices) : 1;
    endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Bundle of request, sample, configuration and result signals for the mixer.
// master: the block that requests frames and writes gains.
// slave : the mixer itself.
interface voice_mixer_if
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES = 6,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8
);
    localparam int ADDR_W = addr_width(NUM_VOICES);

    logic                           sample_req;
    logic [NUM_VOICES*SAMPLE_W-1:0] vin;
    logic                           cfg_we;
    logic [ADDR_W-1:0]              cfg_addr;
    logic                           cfg_sel;
    logic [GAIN_W-1:0]              cfg_data;
    logic                           status_clr;
    logic [2*SAMPLE_W-1:0]          stereo_out;
    logic                           out_valid;
    logic                           busy;
    logic                           clip;
    logic                           overrun;

    modport master (
        output sample_req, vin, cfg_we, cfg_addr, cfg_sel, cfg_data, status_clr,
        input  stereo_out, out_valid, busy, clip, overrun
    );

    modport slave (
        input  sample_req, vin, cfg_we, cfg_addr, cfg_sel, cfg_data, status_clr,
        output stereo_out, out_valid, busy, clip, overrun
    );

endinterface

// File: rtl/voice_mixer_sat.sv
// mixer_sat: clamps a wide signed accumulator to the signed OUT_W range and
// flags when the clamp was applied. Purely combinational.
module mixer_sat #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout,
    output logic                    o_clip
);
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clamp against the representable extremes of the output width.
    always_comb begin
        o_dout = i_din[OUT_W-1:0];
        o_clip = 1'b0;
        if (i_din > MAX_V) begin
            o_dout = MAX_V[OUT_W-1:0];
            o_clip = 1'b1;
        end else if (i_din < MIN_V) begin
            o_dout = MIN_V[OUT_W-1:0];
            o_clip = 1'b1;
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: multiply-accumulate mixer of NUM_VOICES signed samples into a
// saturated stereo frame, one voice per cycle, with shadowed gain banks.
// Build option: define VOICE_MIXER_PAN_EN for independent left/right gain
// banks; without it a single bank drives both channels and cfg_sel is unused.
module voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES = 6,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8
) (
    input  logic          clk147,
    input  logic          rst_n,
    voice_mixer_if.slave  bus
);
    localparam int ACC_W  = acc_width(SAMPLE_W, NUM_VOICES);
    localparam int ADDR_W = addr_width(NUM_VOICES);
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_W));

    state_e                     r_state;
    state_e                     w_next;
    logic                       w_accept;
    logic                       w_acc_en;
    logic                       w_sat_en;
    logic                       w_out_en;
    logic                       w_last;
    logic                       w_cfg_ok;

    logic [ADDR_W-1:0]          r_idx;
    logic signed [SAMPLE_W-1:0] r_vin [NUM_VOICES];
    logic [GAIN_W-1:0]          r_gain_l_sh  [NUM_VOICES];
    logic [GAIN_W-1:0]          r_gain_l_act [NUM_VOICES];
    logic [GAIN_W-1:0]          w_gain_l;
    logic [GAIN_W-1:0]          w_gain_r;

    logic signed [PROD_W-1:0]   w_prod_l;
    logic signed [PROD_W-1:0]   w_prod_r;
    logic signed [ACC_W-1:0]    w_term_l;
    logic signed [ACC_W-1:0]    w_term_r;
    logic signed [ACC_W-1:0]    r_acc_l;
    logic signed [ACC_W-1:0]    r_acc_r;

    logic signed [SAMPLE_W-1:0] w_sat_l;
    logic signed [SAMPLE_W-1:0] w_sat_r;
    logic                       w_clip_l;
    logic                       w_clip_r;
    logic [SAMPLE_W-1:0]        r_sat_l;
    logic [SAMPLE_W-1:0]        r_sat_r;
    logic [2*SAMPLE_W-1:0]      r_stereo;
    logic                       r_out_valid;
    logic                       r_clip;
    logic                       r_overrun;

    assign w_last   = (r_idx == ADDR_W'(NUM_VOICES - 1));
    assign w_cfg_ok = bus.cfg_we && (32'(bus.cfg_addr) < 32'(NUM_VOICES));

    // FSM state register.
    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next state and per-state datapath enables.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_next   = r_state;
        w_accept = 1'b0;
        w_acc_en = 1'b0;
        w_sat_en = 1'b0;
        w_out_en = 1'b0;
        unique case (r_state)
            IDLE: if (bus.sample_req) begin
                      w_accept = 1'b1;
                      w_next   = ACC;
                  end
            ACC:  begin
                      w_acc_en = 1'b1;
                      if (w_last) w_next = SAT;
                  end
            SAT:  begin
                      w_sat_en = 1'b1;
                      w_next   = OUT;
                  end
            OUT:  begin
                      w_out_en = 1'b1;
                      w_next   = IDLE;
                  end
            default: w_next = IDLE;
        endcase
    end

    // Snapshot of the voice samples taken when a frame is accepted.
    always_ff @(posedge clk147) begin
        // NOTE: this array has no reset on purpose; it is always loaded on
        // acceptance before ACC reads it, so resetting it would only add logic.
        if (w_accept) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_vin[i] <= bus.vin[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

`ifdef VOICE_MIXER_PAN_EN
    logic [GAIN_W-1:0] r_gain_r_sh  [NUM_VOICES];
    logic [GAIN_W-1:0] r_gain_r_act [NUM_VOICES];
    logic              w_wr_l;
    logic              w_wr_r;

    assign w_wr_l = w_cfg_ok && !bus.cfg_sel;
    assign w_wr_r = w_cfg_ok &&  bus.cfg_sel;

    // Right gain bank: shadow written any time, copied to active on acceptance.
    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_gain_r_sh[i]  <= UNITY;
                r_gain_r_act[i] <= UNITY;
            end
        end else begin
            if (w_wr_r)   r_gain_r_sh[bus.cfg_addr] <= bus.cfg_data;
            if (w_accept) r_gain_r_act <= r_gain_r_sh;
        end
    end

    assign w_gain_r = r_gain_r_act[r_idx];
`else
    logic w_wr_l;

    assign w_wr_l   = w_cfg_ok;
    assign w_gain_r = w_gain_l;
`endif

    // Left (or sole) gain bank: shadow written any time, copied on acceptance.
    always_ff @(posedge clk147 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_gain_l_sh[i]  <= UNITY;
                r_gain_l_act[i] <= UNITY;
            end
        end else begin
            if (w_wr_l)   r_gain_l_sh[bus.cfg_addr] <= bus.cfg_data;
            if (w_accept) r_gain_l_act <= r_gain_l_sh;
        end
    end

    assign w_gain_l = r_gain_l_act[r_idx];

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign w_prod_l = r_vin[r_idx] * $signed({1'b0, w_gain_l});
    assign w_prod_r = r_vin[r_idx] * $signed({1'b0, w_gain_r});
    assign w_term_l = ACC_W'(w_prod_l >>> (GAIN_W - 1));
    assign w_term_r = ACC_W'(w_prod_r >>> (GAIN_W - 1));

    mixer_sat #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat_l (
        .i_din  (r_acc_l),
        .o_dout (w_sat_l),
        .o_clip (w_clip_l)
    );

    mixer_sat #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat_r (
        .i_din  (r_acc_r),
        .o_dout (w_sat_r),
        .o_clip (w_clip_r)
    );

    // Accumulate, saturate, publish the frame and track the sticky flags.
    always_ff @(posedge clk147 or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values of its neighbours, independent of statement order.
        if (!rst_n) begin
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_sat_l     <= '0;
            r_sat_r     <= '0;
            r_stereo    <= '0;
            r_out_valid <= 1'b0;
            r_clip      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= w_out_en;

            if (w_accept) begin
                r_idx   <= '0;
                r_acc_l <= '0;
                r_acc_r <= '0;
            end else if (w_acc_en) begin
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                r_acc_l <= r_acc_l + w_term_l;
                r_acc_r <= r_acc_r + w_term_r;
            end

            if (w_sat_en) begin
                r_sat_l <= w_sat_l;
                r_sat_r <= w_sat_r;
            end

            if (w_out_en) r_stereo <= {r_sat_l, r_sat_r};

            // A set event in the same cycle as a clear takes priority.
            if (w_sat_en && (w_clip_l || w_clip_r)) r_clip <= 1'b1;
            else if (bus.status_clr)                r_clip <= 1'b0;

            if (bus.sample_req && (r_state != IDLE)) r_overrun <= 1'b1;
            else if (bus.status_clr)                 r_overrun <= 1'b0;
        end
    end

    assign bus.stereo_out = r_stereo;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = (r_state != IDLE);
    assign bus.clip       = r_clip;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer (default parameters).
// Expected values are hand-computed; right-channel expectations depend on
// whether VOICE_MIXER_PAN_EN is defined for the build.
module tb_voice_mixer;
    import mixer_pkg::*;

    localparam int NV = 6;
    localparam int SW = 16;
    localparam int GW = 8;

    logic clk147 = 1'b0;
    logic rst_n  = 1'b0;

    always #5 clk147 = ~clk147;

    voice_mixer_if #(.NUM_VOICES(NV), .SAMPLE_W(SW), .GAIN_W(GW)) bus ();

    voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .GAIN_W(GW)) dut (
        .clk147 (clk147),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] st(input int l, input int r);
        logic [15:0] lw;
        logic [15:0] rw;
        lw = 16'(l);
        rw = 16'(r);
        return {32'd0, lw, rw};
    endfunction

    task automatic tick();
        @(posedge clk147);
        #1;
    endtask

    task automatic set_vin(input int i, input int v);
        bus.vin[i*SW +: SW] = 16'(v);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NV; i++) bus.vin[i*SW +: SW] = 16'(v);
    endtask

    task automatic cfg(input int a, input logic s, input int d);
        bus.cfg_addr = 3'(a);
        bus.cfg_sel  = s;
        bus.cfg_data = 8'(d);
        bus.cfg_we   = 1'b1;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_frame(output int lat);
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        wait_valid(lat);
    endtask

    task automatic clear_flags();
        bus.status_clr = 1'b1;
        tick();
        bus.status_clr = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] cap;
        int exp_r1;
        int exp_r2;
`ifdef VOICE_MIXER_PAN_EN
        exp_r1 = 0;
        exp_r2 = 0;
`else
        exp_r1 = -1000;
        exp_r2 = -2000;
`endif
        bus.sample_req = 1'b0;
        bus.vin        = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_sel    = 1'b0;
        bus.cfg_data   = '0;
        bus.status_clr = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_stereo",  64'(bus.stereo_out), 64'd0);
        check("rst_valid",   64'(bus.out_valid),  64'd0);
        check("rst_busy",    64'(bus.busy),       64'd0);
        check("rst_clip",    64'(bus.clip),       64'd0);
        check("rst_overrun", 64'(bus.overrun),    64'd0);
        rst_n = 1'b1;
        tick();

        // Unity gains, all voices 1000
        set_all(1000);
        run_frame(lat);
        check("basic_latency", 64'(lat), 64'd9);
        check("basic_stereo",  64'(bus.stereo_out), st(6000, 6000));
        check("basic_clip",    64'(bus.clip), 64'd0);
        check("basic_busy",    64'(bus.busy), 64'd0);
        tick();
        check("basic_pulse_end", 64'(bus.out_valid), 64'd0);
        check("basic_hold",      64'(bus.stereo_out), st(6000, 6000));

        // Mixed signs at unity: 100-200+300-400+500-600 = -300
        set_vin(0, 100); set_vin(1, -200); set_vin(2, 300);
        set_vin(3, -400); set_vin(4, 500); set_vin(5, -600);
        run_frame(lat);
        check("mixed_stereo", 64'(bus.stereo_out), st(-300, -300));

        // Positive saturation, then clear
        set_all(32767);
        run_frame(lat);
        check("satpos_stereo", 64'(bus.stereo_out), st(32767, 32767));
        check("satpos_clip",   64'(bus.clip), 64'd1);
        clear_flags();
        check("clip_cleared",  64'(bus.clip), 64'd0);

        // Negative saturation with status_clr coincident with the SAT cycle
        set_all(-32768);
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        repeat (6) tick();
        bus.status_clr = 1'b1;
        tick();
        bus.status_clr = 1'b0;
        check("clip_set_wins", 64'(bus.clip), 64'd1);
        tick();
        check("satneg_valid",  64'(bus.out_valid), 64'd1);
        check("satneg_stereo", 64'(bus.stereo_out), st(-32768, -32768));
        clear_flags();

        // Panned voice 0: left 64 (x0.5), right 0, others 0; bad addresses ignored
        for (int v = 1; v < NV; v++) begin
            cfg(v, 1'b0, 0);
            cfg(v, 1'b1, 0);
        end
        cfg(0, 1'b1, 0);
        cfg(0, 1'b0, 64);
        cfg(7, 1'b0, 255);
        cfg(6, 1'b1, 255);
        set_all(5000);
        set_vin(0, -2000);
        run_frame(lat);
        check("pan_stereo", 64'(bus.stereo_out), st(-1000, exp_r1));

        // Gain write coincident with an accepted request
        bus.cfg_addr   = 3'd0;
        bus.cfg_sel    = 1'b0;
        bus.cfg_data   = 8'd128;
        bus.cfg_we     = 1'b1;
        bus.sample_req = 1'b1;
        tick();
        bus.cfg_we     = 1'b0;
        bus.sample_req = 1'b0;
        wait_valid(lat);
        check("cfgsync_latency", 64'(lat), 64'd9);
        check("cfgsync_old",     64'(bus.stereo_out), st(-1000, exp_r1));
        run_frame(lat);
        check("cfgsync_new",     64'(bus.stereo_out), st(-2000, exp_r2));

        // Second request 3 cycles into a frame
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        tick();
        tick();
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        check("overrun_set", 64'(bus.overrun), 64'd1);
        pulses = 0;
        cap    = '0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                pulses++;
                cap = bus.stereo_out;
            end
        end
        check("overrun_pulses", 64'(pulses), 64'd1);
        check("overrun_frame",  64'(cap), st(-2000, exp_r2));
        check("overrun_idle",   64'(bus.busy), 64'd0);
        clear_flags();
        check("overrun_cleared", 64'(bus.overrun), 64'd0);

        // Request landing in the OUT cycle is treated as busy
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        repeat (7) tick();
        check("out_busy", 64'(bus.busy), 64'd1);
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        check("out_valid",   64'(bus.out_valid), 64'd1);
        check("out_overrun", 64'(bus.overrun), 64'd1);
        tick();
        check("out_no_restart", 64'(bus.busy), 64'd0);
        tick();
        check("out_still_idle", 64'(bus.busy), 64'd0);

        // Reset asserted mid-ACC
        set_all(1000);
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_stereo",  64'(bus.stereo_out), 64'd0);
        check("midrst_valid",   64'(bus.out_valid),  64'd0);
        check("midrst_busy",    64'(bus.busy),       64'd0);
        check("midrst_overrun", 64'(bus.overrun),    64'd0);
        check("midrst_clip",    64'(bus.clip),       64'd0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.out_valid === 1'b1) pulses++;
        end
        check("midrst_no_pulse", 64'(pulses), 64'd0);

        // Gains back at unity after reset
        run_frame(lat);
        check("post_rst_latency", 64'(lat), 64'd9);
        check("post_rst_stereo",  64'(bus.stereo_out), st(6000, 6000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
